// File: rtl/ysyx_22040632_lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_RISCV_PKG
// Purpose  : Shared types and helpers for the load/store sequencer.
//            - lsu_size_e   : access size (B/H/W/D)
//            - lsu_state_e  : sequencer FSM states
//            - lsu_misaligned() : natural-alignment check on the byte offset
//            - lsu_strb()       : byte-lane mask for a doubleword bus beat
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040632_RISCV_PKG;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2,
        LSU_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // An access is aligned when its offset is a multiple of its size.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [2:0] off);
        logic mis;
        case (size)
            LSU_H:   mis = off[0];
            LSU_W:   mis = (off[1:0] != 2'b00);
            LSU_D:   mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Contiguous mask of 1/2/4/8 bytes, moved up to the addressed lane.
    function automatic logic [7:0] lsu_strb(input lsu_size_e size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            LSU_B:   base = 8'h01;
            LSU_H:   base = 8'h03;
            LSU_W:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040632_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_lsu_align
// Purpose  : Combinational lane steering for the load/store sequencer.
//            Store side: shifts right-aligned store data into its byte lane
//            and builds the byte strobes. Load side: pulls the addressed
//            bytes down from the read doubleword and sign/zero extends them.
// Ports    : st_size/st_off/st_wdata  -> st_lane_wdata, st_strb
//            ld_size/ld_signed/ld_off/ld_rdata -> ld_data
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040632_lsu_align
    import ysyx_22040632_RISCV_PKG::*;
(
    input  logic [1:0]  st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_wdata,
    output logic [63:0] st_lane_wdata,
    output logic [7:0]  st_strb,

    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [63:0] w_ld_shift;

    assign st_lane_wdata = st_wdata << {st_off, 3'b000};
    assign st_strb       = lsu_strb(lsu_size_e'(st_size), st_off);

    assign w_ld_shift    = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = w_ld_shift;
        case (lsu_size_e'(ld_size))
            LSU_B:   ld_data = {{56{ld_signed & w_ld_shift[7]}},  w_ld_shift[7:0]};
            LSU_H:   ld_data = {{48{ld_signed & w_ld_shift[15]}}, w_ld_shift[15:0]};
            LSU_W:   ld_data = {{32{ld_signed & w_ld_shift[31]}}, w_ld_shift[31:0]};
            default: ld_data = w_ld_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040632_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_lsu_ctrl
// Purpose  : Load/store sequencer between the execute stage and a 64-bit
//            valid/ready memory port with one outstanding request.
//            Latches a request, issues one doubleword-aligned bus beat,
//            waits for read data (bounded by TIMEOUT) and returns a
//            one-cycle response with extended load data or an error.
// Ports    : req_*  - request from execute (valid/ready)
//            resp_* - one-cycle response pulse (always accepted)
//            mem_*  - memory request channel (valid/ready) and read return
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040632_lsu_ctrl
    import ysyx_22040632_RISCV_PKG::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,

    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    // The counter only has to reach TIMEOUT-1; expiry is detected one count early
    // so the response lands exactly TIMEOUT cycles after entering WAIT_R.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    lsu_state_e         r_state;
    lsu_state_e         w_state_next;

    logic [1:0]         r_size;
    logic               r_signed;
    logic [2:0]         r_off;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [63:0]        r_mem_wdata;
    logic [7:0]         r_mem_wstrb;
    logic [63:0]        r_resp_rdata;
    logic               r_resp_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_misaligned;
    logic               w_expire;
    logic               w_accept;
    logic               w_resp_err;
    logic               w_resp_store;
    logic               w_resp_load;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic [63:0]        w_lane_wdata;
    logic [7:0]         w_strb;
    logic [63:0]        w_ld_data;

    ysyx_22040632_lsu_align u_align (
        .st_size       (req_size),
        .st_off        (req_addr[2:0]),
        .st_wdata      (req_wdata),
        .st_lane_wdata (w_lane_wdata),
        .st_strb       (w_strb),
        .ld_size       (r_size),
        .ld_signed     (r_signed),
        .ld_off        (r_off),
        .ld_rdata      (mem_rdata),
        .ld_data       (w_ld_data)
    );

    assign w_misaligned = lsu_misaligned(lsu_size_e'(req_size), req_addr[2:0]);
    assign w_expire     = (TIMEOUT != 0) && (32'(r_cnt) == TIMEOUT - 1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_store = 1'b0;
        w_resp_load  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        req_ready    = (r_state == IDLE);
        mem_valid    = (r_state == ISSUE);
        resp_valid   = (r_state == RESP);

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_misaligned) begin
                        // Rejected without touching the bus.
                        w_resp_err   = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (r_mem_we) begin
                        w_resp_store = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                // Read data arriving in the expiry cycle takes priority.
                if (mem_rvalid) begin
                    w_resp_load  = 1'b1;
                    w_state_next = RESP;
                end else if (w_expire) begin
                    w_resp_err   = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, bus beat and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_off        <= 3'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 64'd0;
            r_mem_wstrb  <= 8'd0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_size      <= req_size;
                r_signed    <= req_signed;
                r_off       <= req_addr[2:0];
                r_mem_we    <= req_we;
                r_mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                r_mem_wdata <= req_we ? w_lane_wdata : 64'd0;
                r_mem_wstrb <= req_we ? w_strb : 8'd0;
            end

            if (w_resp_err) begin
                r_resp_err   <= 1'b1;
                r_resp_rdata <= 64'd0;
            end else if (w_resp_store) begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= 64'd0;
            end else if (w_resp_load) begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= w_ld_data;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040632_lsu_ctrl
// Purpose  : Self-checking bench for the load/store sequencer. A vector table
//            drives single transactions with a scripted memory responder;
//            expected responses are queued at accept time and compared when
//            resp_valid appears. Hand sequences cover reset in WAIT_R and
//            back-to-back requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040632_lsu_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned ADDR_W  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = 64'd0;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_rvalid = 1'b0;
    logic [63:0]       mem_rdata = 64'd0;

    ysyx_22040632_lsu_ctrl #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ready_dly;   // stall cycles before mem_ready
        int          rvalid_dly;  // cycles after handshake until rvalid; -1 = never
        logic        bus;         // bus beat expected
        logic [63:0] exp_maddr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_mwdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          lat;         // accept cycle to resp_valid cycle
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int ready_dly,
                                input int rvalid_dly, input logic bus,
                                input logic [63:0] exp_maddr, input logic [7:0] exp_strb,
                                input logic [63:0] exp_mwdata, input logic exp_err,
                                input logic [63:0] exp_rdata, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ready_dly = ready_dly; v.rvalid_dly = rvalid_dly;
        v.bus = bus; v.exp_maddr = exp_maddr; v.exp_strb = exp_strb;
        v.exp_mwdata = exp_mwdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.lat = lat;
        return v;
    endfunction

    // Scoreboard: every resp_valid cycle must match the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid with nothing pending at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                    check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: %0d responses missing at cycle %0d", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        check($sformatf("v%0d req_ready", id), {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.acc   = cyc;
        e.lat   = v.lat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '1;           // scramble to prove the request was latched
        req_wdata = '1;
        req_size  = ~v.size;
        if (v.bus) begin
            check($sformatf("v%0d mem_valid", id), {63'd0, mem_valid}, 64'd1);
            check($sformatf("v%0d mem_addr", id), mem_addr, v.exp_maddr);
            check($sformatf("v%0d mem_wstrb", id), {56'd0, mem_wstrb}, {56'd0, v.exp_strb});
            check($sformatf("v%0d mem_we", id), {63'd0, mem_we}, {63'd0, v.we});
            if (v.we) check($sformatf("v%0d mem_wdata", id), mem_wdata, v.exp_mwdata);
            for (int i = 0; i < v.ready_dly; i++) begin
                @(negedge clk);
                check($sformatf("v%0d mem_valid_stall", id), {63'd0, mem_valid}, 64'd1);
                check($sformatf("v%0d mem_addr_stall", id), mem_addr, v.exp_maddr);
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            check($sformatf("v%0d mem_valid_drop", id), {63'd0, mem_valid}, 64'd0);
            if (v.rvalid_dly > 0) begin
                for (int k = 1; k < v.rvalid_dly; k++) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
            end
        end else begin
            check($sformatf("v%0d no_mem_valid", id), {63'd0, mem_valid}, 64'd0);
        end
        drain();
    endtask

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v_ld;
        exp_t e;

        //          we size sgn addr                   wdata          rdata                     rdy rv  bus maddr                 strb   mwdata                    err rdata                     lat
        vecs[0]  = mk(1, 2, 0, 64'h8000_0004, 64'h1122_3344, 64'd0,                    0,  0, 1, 64'h8000_0000, 8'hF0, 64'h1122_3344_0000_0000, 0, 64'd0,                    2);
        vecs[1]  = mk(0, 0, 1, 64'h8000_0103, 64'd0, 64'h0000_0000_80FF_0000,          3,  2, 1, 64'h8000_0100, 8'h00, 64'd0,                   0, 64'hFFFF_FFFF_FFFF_FF80, 7);
        vecs[2]  = mk(0, 0, 0, 64'h8000_0103, 64'd0, 64'h0000_0000_80FF_0000,          3,  2, 1, 64'h8000_0100, 8'h00, 64'd0,                   0, 64'h80,                  7);
        vecs[3]  = mk(0, 1, 0, 64'h8000_0001, 64'd0, 64'd0,                            0,  0, 0, 64'd0,         8'h00, 64'd0,                   1, 64'd0,                   1);
        vecs[4]  = mk(0, 2, 1, 64'h8000_0010, 64'd0, 64'd0,                            0, -1, 1, 64'h8000_0010, 8'h00, 64'd0,                   1, 64'd0,                   6);
        vecs[5]  = mk(0, 2, 1, 64'h8000_0014, 64'd0, 64'hFEDC_BA98_7654_3210,          0,  4, 1, 64'h8000_0010, 8'h00, 64'd0,                   0, 64'hFFFF_FFFF_FEDC_BA98, 6);
        vecs[6]  = mk(0, 1, 0, 64'h8000_0026, 64'd0, 64'h8123_4567_89AB_CDEF,          0,  1, 1, 64'h8000_0020, 8'h00, 64'd0,                   0, 64'h8123,                3);
        vecs[7]  = mk(0, 1, 1, 64'h8000_0026, 64'd0, 64'h8123_4567_89AB_CDEF,          0,  1, 1, 64'h8000_0020, 8'h00, 64'd0,                   0, 64'hFFFF_FFFF_FFFF_8123, 3);
        vecs[8]  = mk(0, 3, 1, 64'h8000_0038, 64'd0, 64'hDEAD_BEEF_0123_4567,          0,  1, 1, 64'h8000_0038, 8'h00, 64'd0,                   0, 64'hDEAD_BEEF_0123_4567, 3);
        vecs[9]  = mk(1, 1, 0, 64'h8000_0042, 64'hABCD, 64'd0,                         2,  0, 1, 64'h8000_0040, 8'h0C, 64'h0000_0000_ABCD_0000, 0, 64'd0,                   4);
        vecs[10] = mk(1, 3, 0, 64'h8000_0054, 64'h1, 64'd0,                            0,  0, 0, 64'd0,         8'h00, 64'd0,                   1, 64'd0,                   1);
        vecs[11] = mk(0, 2, 0, 64'h8000_0064, 64'd0, 64'h8000_0001_0000_0000,          0,  1, 1, 64'h8000_0060, 8'h00, 64'd0,                   0, 64'h8000_0001,           3);
        vecs[12] = mk(0, 0, 1, 64'h8000_0070, 64'd0, 64'h1234_5678_9ABC_DE7F,          0,  1, 1, 64'h8000_0070, 8'h00, 64'd0,                   0, 64'h7F,                  3);
        vecs[13] = mk(0, 2, 0, 64'h8000_0080, 64'd0, 64'h0000_0000_CAFE_F00D,          0,  3, 1, 64'h8000_0080, 8'h00, 64'd0,                   0, 64'hCAFE_F00D,           5);
        vecs[14] = mk(0, 2, 0, 64'h8000_0090, 64'd0, 64'h1111_2222_3333_4444,          0,  5, 1, 64'h8000_0090, 8'h00, 64'd0,                   1, 64'd0,                   6);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst resp_err", {63'd0, resp_err}, 64'd0);
        check("rst resp_rdata", resp_rdata, 64'd0);
        check("rst mem_valid", {63'd0, mem_valid}, 64'd0);
        check("rst mem_we", {63'd0, mem_we}, 64'd0);
        check("rst mem_addr", mem_addr, 64'd0);
        check("rst mem_wdata", mem_wdata, 64'd0);
        check("rst mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst req_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < NV; i++) run_txn(i, vecs[i]);

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 64'h8000_0108;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw req_ready", {63'd0, req_ready}, 64'd1);
        check("rstw mem_valid", {63'd0, mem_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw no_resp", {63'd0, resp_valid}, 64'd0);
            check("rstw idle_ready", {63'd0, req_ready}, 64'd1);
            check("rstw idle_mem_valid", {63'd0, mem_valid}, 64'd0);
        end
        v_ld = mk(0, 3, 0, 64'h8000_0108, 64'd0, 64'h0102_0304_0506_0708, 0, 1, 1,
                  64'h8000_0108, 8'h00, 64'd0, 0, 64'h0102_0304_0506_0708, 3);
        run_txn(100, v_ld);

        // Back-to-back stores with req_valid held high and mem_ready always 1.
        @(negedge clk);
        check("b2b first_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'h8000_0207; req_wdata = 64'hA5;
        mem_ready = 1'b1;
        e.rdata = 64'd0; e.err = 1'b0; e.acc = cyc; e.lat = 2;
        exp_q.push_back(e);
        @(negedge clk);
        check("b2b sb mem_valid", {63'd0, mem_valid}, 64'd1);
        check("b2b sb mem_addr", mem_addr, 64'h8000_0200);
        check("b2b sb mem_wstrb", {56'd0, mem_wstrb}, 64'h80);
        check("b2b sb mem_wdata", mem_wdata, 64'hA500_0000_0000_0000);
        req_size = 2'd3; req_addr = 64'h8000_0208; req_wdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("b2b resp_not_ready", {63'd0, req_ready}, 64'd0);
        check("b2b resp_no_mem", {63'd0, mem_valid}, 64'd0);
        e.rdata = 64'd0; e.err = 1'b0; e.acc = cyc + 1; e.lat = 2;
        exp_q.push_back(e);
        @(negedge clk);
        check("b2b second_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b sd mem_valid", {63'd0, mem_valid}, 64'd1);
        check("b2b sd mem_addr", mem_addr, 64'h8000_0208);
        check("b2b sd mem_wstrb", {56'd0, mem_wstrb}, 64'hFF);
        check("b2b sd mem_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        mem_ready = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
